posit_adder_es2_axil_slave: RTL and testbench

AXI4-Lite responder that fronts the es=2 posit adder core. It is the slave end of the S00_AXI register port that the master VIP drives. It holds two operand registers, launches the core with a one-cycle start pulse, captures the result on core completion, and exposes busy/done status. It is instantiated inside the posit_adder_es2 IP wrapper, between the AXI interconnect and the adder datapath.

---
 rtl/posit_adder_es2_axil_slave_if.sv | 52 +++++
 rtl/posit_adder_es2_axil_slave.sv | 171 +++++++++++++++++
 tb/tb_posit_adder_es2_axil_slave.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_adder_es2_axil_slave_if.sv
// AXI4-Lite register-port bundle between the interconnect (master) and the
// posit adder register block (slave).
interface posit_adder_es2_axil_slave_if #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 32
) ();
  logic [AddrWidth-1:0]   awaddr;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [AddrWidth-1:0]   araddr;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready;
  logic [DataWidth-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/posit_adder_es2_axil_slave.sv
// AXI4-Lite register block for the es=2 posit adder: operand registers, launch
// pulse, result capture and busy/done status.
module posit_adder_es2_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  posit_adder_es2_axil_slave_if.slave   s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] core_a,
  output logic [C_S_AXI_DATA_WIDTH-1:0] core_b,
  output logic                          core_start,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] core_result,
  input  logic                          core_done
);
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic          aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [1:0]    aw_sel_q, aw_sel_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d, op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic          busy_q, busy_d, done_q, done_d, start_q, start_d;
  logic          awready, wready, arready, commit;
  logic [DW-1:0] rd_word;
  logic          unused_bits;

  assign awaddr      = s_axi.awaddr;
  assign araddr      = s_axi.araddr;
  assign unused_bits = ^{awaddr[1:0], araddr[1:0], s_axi.awprot, s_axi.arprot};

  assign awready = !aw_full_q && !bvalid_q;
  assign wready  = !w_full_q && !bvalid_q;
  assign arready = !rvalid_q;
  // Both holding registers full: the write lands at the coming edge.
  assign commit  = aw_full_q && w_full_q;

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.arready = arready;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rvalid  = rvalid_q;
  assign core_a        = op_a_q;
  assign core_b        = op_b_q;
  assign core_start    = start_q;

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_word,
                                                input logic [DW-1:0] new_word,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < SW; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    rd_word = '0;
    unique case (araddr[3:2])
      2'd0: rd_word = op_a_q;
      2'd1: rd_word = op_b_q;
      2'd2: rd_word = {{(DW-2){1'b0}}, busy_q, done_q};
      2'd3: rd_word = result_q;
    endcase
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_sel_d  = aw_sel_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = done_q;
    start_d   = 1'b0;

    if (s_axi.awvalid && awready) begin
      aw_full_d = 1'b1;
      aw_sel_d  = awaddr[3:2];
    end
    if (s_axi.wvalid && wready) begin
      w_full_d = 1'b1;
      w_data_d = s_axi.wdata;
      w_strb_d = s_axi.wstrb;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else if (bvalid_q && s_axi.bready) begin
      bvalid_d = 1'b0;
    end

    if (core_done && busy_q) begin
      result_d = core_result;
      done_d   = 1'b1;
      busy_d   = 1'b0;
    end

    // Launch is judged on the pre-edge busy, so a same-cycle core_done wins.
    if (commit) begin
      unique case (aw_sel_q)
        2'd0: op_a_d = merge_bytes(op_a_q, w_data_q, w_strb_q);
        2'd1: op_b_d = merge_bytes(op_b_q, w_data_q, w_strb_q);
        2'd2: begin
          if (w_strb_q[0] && w_data_q[0] && !busy_q) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
        2'd3: ;
      endcase
    end

    if (s_axi.arvalid && arready) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      aw_sel_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_sel_q  <= aw_sel_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
    end
  end
endmodule

// File: tb/tb_posit_adder_es2_axil_slave.sv
// Directed bench for the posit adder AXI4-Lite register block, with a
// register-file model and a per-cycle response checker.
module tb_posit_adder_es2_axil_slave;
  localparam logic [3:0] AOpA = 4'h0;
  localparam logic [3:0] AOpB = 4'h4;
  localparam logic [3:0] ACtrl = 4'h8;
  localparam logic [3:0] ARes = 4'hC;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] core_a, core_b, core_result;
  logic        core_start, core_done;

  posit_adder_es2_axil_slave_if #(.AddrWidth(4), .DataWidth(32)) bus ();

  posit_adder_es2_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .s_axi      (bus),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_start (core_start),
    .core_result(core_result),
    .core_done  (core_done)
  );

  always #5 ACLK = ~ACLK;

  int          n_pass, n_total, n_starts, m_starts;
  logic [31:0] m_op_a, m_op_b, m_result;
  logic        m_busy, m_done, prev_start;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: handshake bound expired", name);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // ---- register-file model ----
  task automatic model_reset();
    m_op_a = '0; m_op_b = '0; m_result = '0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  function automatic logic [31:0] bytes_in(input logic [31:0] o, input logic [31:0] d,
                                           input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a[3:2])
      2'd0:    return m_op_a;
      2'd1:    return m_op_b;
      2'd2:    return {30'd0, m_busy, m_done};
      default: return m_result;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[3:2])
      2'd0: m_op_a = bytes_in(m_op_a, d, s);
      2'd1: m_op_b = bytes_in(m_op_b, d, s);
      2'd2: if (s[0] && d[0] && !m_busy) begin
        m_busy = 1'b1; m_done = 1'b0; m_starts++;
      end
      default: ;
    endcase
  endtask

  task automatic model_done(input logic [31:0] v);
    if (m_busy) begin
      m_result = v; m_done = 1'b1; m_busy = 1'b0;
    end
  endtask

  // ---- per-cycle response checker ----
  task automatic compare_loop();
    logic [31:0] e;
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (bus.rvalid && bus.rready) begin
          if (exp_q.size() == 0) timeout("rdata_unexpected");
          else begin
            e = exp_q.pop_front();
            check("rdata_model", bus.rdata, e);
            check("rresp", {30'd0, bus.rresp}, 32'd0);
          end
        end
        if (bus.bvalid && bus.bready) check("bresp", {30'd0, bus.bresp}, 32'd0);
        if (core_start) begin
          n_starts++;
          check("core_a_at_start", core_a, m_op_a);
          check("core_b_at_start", core_b, m_op_b);
          check("start_single_cycle", {31'd0, prev_start}, 32'd0);
        end
        prev_start = core_start;
      end else begin
        prev_start = 1'b0;
      end
    end
  endtask

  // ---- bus drivers ----
  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int hold, input logic inj,
                           input logic [31:0] inj_val, output logic [1:0] resp);
    bit ok_aw, ok_w;
    ok_aw = 0; ok_w = 0;
    fork
      begin
        if (lead > 0) repeat (lead) tick();
        bus.awaddr = a; bus.awvalid = 1'b1;
        for (int i = 0; i < 50 && !ok_aw; i++) begin
          @(negedge ACLK); ok_aw = bus.awready; tick();
        end
        bus.awvalid = 1'b0;
      end
      begin
        if (lead < 0) repeat (-lead) tick();
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        for (int j = 0; j < 50 && !ok_w; j++) begin
          @(negedge ACLK); ok_w = bus.wready; tick();
        end
        bus.wvalid = 1'b0;
      end
    join
    if (!ok_aw) timeout("aw_handshake");
    if (!ok_w) timeout("w_handshake");
    // Both holding registers are full in this cycle; commit at its end.
    model_write(a, d, s);
    if (inj) begin
      core_result = inj_val; core_done = 1'b1;
      model_done(inj_val);
    end
    tick();
    core_done = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge ACLK);
      check("bvalid_held", {31'd0, bus.bvalid}, 32'd1);
      check("awready_low_during_b", {31'd0, bus.awready}, 32'd0);
      tick();
    end
    bus.bready = 1'b1;
    @(negedge ACLK);
    check("bvalid_up", {31'd0, bus.bvalid}, 32'd1);
    resp = bus.bresp;
    tick();
    bus.bready = 1'b0;
    @(negedge ACLK);
    check("bvalid_cleared", {31'd0, bus.bvalid}, 32'd0);
    check("ready_back", {30'd0, bus.awready, bus.wready}, 32'd3);
    tick();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, 0, 0, 1'b0, 32'd0, r);
  endtask

  task automatic axi_read(input logic [3:0] a, input int hold, output logic [31:0] d);
    bit ok;
    ok = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge ACLK);
      ok = bus.arready;
      if (ok) exp_q.push_back(model_read(a));
      tick();
    end
    bus.arvalid = 1'b0;
    if (!ok) timeout("ar_handshake");
    @(negedge ACLK);
    check("rvalid_next_cycle", {31'd0, bus.rvalid}, 32'd1);
    d = bus.rdata;
    for (int k = 0; k < hold; k++) begin
      tick();
      @(negedge ACLK);
      check("rdata_stable", bus.rdata, d);
    end
    tick();
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    axi_read(a, 0, d);
  endtask

  task automatic core_finish(input int delay, input logic [31:0] v);
    repeat (delay) tick();
    core_result = v; core_done = 1'b1;
    model_done(v);
    tick();
    core_done = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          s0;
    n_pass = 0; n_total = 0; n_starts = 0; m_starts = 0; prev_start = 1'b0;
    model_reset();
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    core_result = '0; core_done = 1'b0;
    ARESET = 1'b1;
    fork
      compare_loop();
    join_none

    @(negedge ACLK);
    check("rst_awready", {31'd0, bus.awready}, 32'd1);
    check("rst_wready", {31'd0, bus.wready}, 32'd1);
    check("rst_arready", {31'd0, bus.arready}, 32'd1);
    check("rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    tick();

    // Plain write/readback
    wr(AOpA, 32'h0000_0001);
    wr(AOpB, 32'h0000_0002);
    rd(AOpA, d); check("opa_readback", d, 32'h0000_0001);
    rd(AOpB, d); check("opb_readback", d, 32'h0000_0002);
    rd(ACtrl, d); check("ctrl_idle", d, 32'h0000_0000);

    // Channel ordering and B backpressure
    axi_write(AOpA, 32'h1111_1111, 4'hF, 3, 4, 1'b0, 32'd0, r);
    axi_write(AOpB, 32'h2222_2222, 4'hF, 0, 4, 1'b0, 32'd0, r);
    axi_write(AOpA, 32'h3333_3333, 4'hF, -2, 0, 1'b0, 32'd0, r);
    rd(AOpA, d); check("opa_aw_first", d, 32'h3333_3333);
    axi_read(AOpB, 3, d); check("opb_same_cycle", d, 32'h2222_2222);

    // 1.0 + 1.0 = 2.0
    wr(AOpA, 32'h4000_0000);
    wr(AOpB, 32'h4000_0000);
    s0 = n_starts;
    wr(ACtrl, 32'h0000_0001);
    check("launch_one_start", n_starts - s0, 32'd1);
    rd(ACtrl, d); check("ctrl_busy", d, 32'h0000_0002);
    core_finish(1, 32'h4800_0000);
    rd(ACtrl, d); check("ctrl_done", d, 32'h0000_0001);
    rd(ARes, d); check("result_2p0", d, 32'h4800_0000);

    // Byte strobes, RESULT write ignored
    wr(AOpA, 32'h0000_0000);
    axi_write(AOpA, 32'hAABB_CCDD, 4'b0010, 0, 0, 1'b0, 32'd0, r);
    rd(AOpA, d); check("opa_strobe", d, 32'h0000_CC00);
    axi_write(ARes, 32'hDEAD_BEEF, 4'hF, 0, 1, 1'b0, 32'd0, r);
    check("bresp_result_write", {30'd0, r}, 32'd0);
    rd(ARes, d); check("result_unchanged", d, 32'h4800_0000);

    // Relaunch while busy, and launch racing core_done
    s0 = n_starts;
    wr(ACtrl, 32'h0000_0001);
    wr(ACtrl, 32'h0000_0001);
    wr(ACtrl, 32'h0000_0001);
    check("relaunch_one_start", n_starts - s0, 32'd1);
    s0 = n_starts;
    axi_write(ACtrl, 32'h0000_0001, 4'hF, 0, 0, 1'b1, 32'h1234_5678, r);
    check("race_no_start", n_starts - s0, 32'd0);
    rd(ACtrl, d); check("race_ctrl_done", d, 32'h0000_0001);
    rd(ARes, d); check("race_result", d, 32'h1234_5678);

    // Reset mid-operation
    wr(ACtrl, 32'h0000_0001);
    tick();
    #2 ARESET = 1'b1;
    #1;
    check("mid_rst_bvalid", {31'd0, bus.bvalid}, 32'd0);
    check("mid_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("mid_rst_rdata", bus.rdata, 32'd0);
    check("mid_rst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'd7);
    check("mid_rst_core_a", core_a, 32'd0);
    check("mid_rst_core_start", {31'd0, core_start}, 32'd0);
    model_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    tick();
    core_finish(0, 32'h7777_7777);
    rd(ACtrl, d); check("post_rst_ctrl", d, 32'h0000_0000);
    rd(ARes, d); check("post_rst_result", d, 32'h0000_0000);
    rd(AOpA, d); check("post_rst_opa", d, 32'h0000_0000);

    check("starts_vs_model", n_starts, m_starts);
    check("starts_total", n_starts, 32'd3);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
